// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared types and constants for the Sudoku game controller.
//   - game_state_e : 4-bit controller state encoding (IDLE=0 .. LOST=8)
//   - DIFF_*       : difficulty input encodings
//   - CELLS_MAX    : largest supported board (9x9)
//   - LFSR_TAPS    : tap mask for the 16-bit hint LFSR (x^16+x^14+x^13+x^11+1,
//                    right-shifting form, so the taps land on bits 0,2,3,5)
package sudoku_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLEAR    = 4'd1,
        S_SET_DIFF = 4'd2,
        S_GEN      = 4'd3,
        S_PLAY     = 4'd4,
        S_CHECK    = 4'd5,
        S_WRONG    = 4'd6,
        S_FIN      = 4'd7,
        S_LOST     = 4'd8
    } game_state_e;

    localparam logic [1:0] DIFF_NONE = 2'b00;
    localparam logic [1:0] DIFF_EASY = 2'b01;
    localparam logic [1:0] DIFF_MED  = 2'b10;
    localparam logic [1:0] DIFF_HARD = 2'b11;

    localparam int CELLS_MAX = 81;

    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // One Fibonacci step: XOR of the tapped bits shifts in at the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    // Four-bit counter increment that sticks at 15.
    function automatic logic [3:0] sat_inc4(input logic [3:0] cur);
        if (cur == 4'd15) begin
            sat_inc4 = cur;
        end else begin
            sat_inc4 = cur + 4'd1;
        end
    endfunction

endpackage

// File: rtl/sudoku_hint_lfsr.sv
// sudoku_hint_lfsr: free-running 16-bit Fibonacci LFSR used to pick hint cells.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, loads SEED
//   en    : advance enable
//   idx_o : low IDX_W bits of the current LFSR value (candidate cell index)
module sudoku_hint_lfsr
    import sudoku_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [IDX_W-1:0] idx_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value.
    always_comb begin
        if (en) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign idx_o = lfsr_q[IDX_W-1:0];

endmodule

// File: rtl/sudoku_game_ctrl.sv
// sudoku_game_ctrl: sequences a Sudoku game (clear, difficulty, hint-mask
// generation, guessing, datapath check with timeout, win/lose).
//   clka/restart        : clock, asynchronous active-high reset
//   enter               : player confirm level (rising edge used)
//   difficulty          : 01 easy, 10 medium, 11 hard, 00 invalid
//   solved/solved_valid : datapath verdict and its one-cycle strobe
//   state               : current state encoding
//   set_board/clear_board, dp_check, fill_flag, wrong_cnt, won, lost : outputs
// Optional feature: define SUDOKU_LOCKOUT_EN to enforce MAX_WRONG and make
// LOST reachable; otherwise WRONG always returns to PLAY and lost is 0.
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int          N             = 4,
    parameter int          HINTS_EASY    = 10,
    parameter int          HINTS_MED     = 7,
    parameter int          HINTS_HARD    = 4,
    parameter int          MAX_WRONG     = 3,
    parameter int          CHECK_TIMEOUT = 15,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             enter,
    input  logic [1:0]       difficulty,
    input  logic             solved,
    input  logic             solved_valid,
    output logic [3:0]       state,
    output logic             set_board,
    output logic             clear_board,
    output logic             dp_check,
    output logic [N*N-1:0]   fill_flag,
    output logic [3:0]       wrong_cnt,
    output logic             won,
    output logic             lost
);

    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam int HCW   = $clog2(CELLS_MAX + 1);
    localparam int TW    = $clog2(CHECK_TIMEOUT + 1);

    localparam logic [HCW-1:0] TGT_EASY    = HCW'(HINTS_EASY);
    localparam logic [HCW-1:0] TGT_MED     = HCW'(HINTS_MED);
    localparam logic [HCW-1:0] TGT_HARD    = HCW'(HINTS_HARD);
    localparam logic [TW-1:0]  TMO_LAST    = TW'(CHECK_TIMEOUT);
    localparam logic [3:0]     WRONG_LIMIT = 4'(MAX_WRONG);
`ifdef SUDOKU_LOCKOUT_EN
    localparam logic LOCKOUT_ON = 1'b1;
`else
    localparam logic LOCKOUT_ON = 1'b0;
`endif

    game_state_e    state_q, state_d;
    logic           enter_q;
    logic [CELLS-1:0] fill_q, fill_d;
    logic [3:0]     wrong_q, wrong_d;
    logic [HCW-1:0] hint_q, hint_d;
    logic [HCW-1:0] target_q, target_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           dp_check_q, dp_check_d;

    logic [IW-1:0]  lfsr_idx_s;
    logic           rise_s;
    logic           idx_ok_s;
    logic           lockout_hit_s;

    sudoku_hint_lfsr #(
        .SEED  (LFSR_SEED),
        .IDX_W (IW)
    ) u_lfsr (
        .clk   (clka),
        .rst   (restart),
        .en    (1'b1),
        .idx_o (lfsr_idx_s)
    );

    assign rise_s        = enter & ~enter_q;
    // A candidate is usable only if it lands on the board and is not yet a hint.
    assign idx_ok_s      = (int'(lfsr_idx_s) < CELLS) && !fill_q[lfsr_idx_s];
    assign lockout_hit_s = LOCKOUT_ON && (wrong_q >= WRONG_LIMIT);

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        wrong_d  = wrong_q;
        hint_d   = hint_q;
        target_d = target_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (rise_s) state_d = S_CLEAR;
                else        state_d = S_IDLE;
            end
            S_CLEAR: begin
                fill_d  = '0;
                wrong_d = 4'd0;
                hint_d  = '0;
                state_d = S_SET_DIFF;
            end
            S_SET_DIFF: begin
                if (rise_s) begin
                    case (difficulty)
                        DIFF_EASY: begin target_d = TGT_EASY; state_d = S_GEN; end
                        DIFF_MED:  begin target_d = TGT_MED;  state_d = S_GEN; end
                        DIFF_HARD: begin target_d = TGT_HARD; state_d = S_GEN; end
                        DIFF_NONE: state_d = S_SET_DIFF;
                        default:   state_d = S_SET_DIFF;
                    endcase
                end else begin
                    state_d = S_SET_DIFF;
                end
            end
            S_GEN: begin
                if (idx_ok_s) begin
                    fill_d[lfsr_idx_s] = 1'b1;
                    hint_d             = hint_q + HCW'(1);
                    if (hint_q + HCW'(1) == target_q) state_d = S_PLAY;
                    else                               state_d = S_GEN;
                end else begin
                    state_d = S_GEN;
                end
            end
            S_PLAY: begin
                if (rise_s) begin
                    state_d = S_CHECK;
                    tmo_d   = '0;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_CHECK: begin
                // A verdict on the timeout cycle takes priority over the timeout.
                if (solved_valid) begin
                    if (solved) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WRONG;
                        wrong_d = sat_inc4(wrong_q);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_WRONG;
                    wrong_d = sat_inc4(wrong_q);
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRONG: begin
                if (rise_s) begin
                    if (lockout_hit_s) state_d = S_LOST;
                    else               state_d = S_PLAY;
                end else begin
                    state_d = S_WRONG;
                end
            end
            S_FIN:   state_d = S_FIN;
            S_LOST:  state_d = S_LOST;
            default: state_d = S_IDLE;
        endcase
        dp_check_d = (state_d == S_CHECK) && (state_q != S_CHECK);
    end

    // Controller registers.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q    <= S_IDLE;
            enter_q    <= 1'b0;
            fill_q     <= '0;
            wrong_q    <= 4'd0;
            hint_q     <= '0;
            target_q   <= '0;
            tmo_q      <= '0;
            dp_check_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enter_q    <= enter;
            fill_q     <= fill_d;
            wrong_q    <= wrong_d;
            hint_q     <= hint_d;
            target_q   <= target_d;
            tmo_q      <= tmo_d;
            dp_check_q <= dp_check_d;
        end
    end

    assign state       = state_q;
    assign set_board   = (state_q == S_CLEAR) || (state_q == S_SET_DIFF);
    assign clear_board = (state_q == S_CLEAR);
    assign dp_check    = dp_check_q;
    assign fill_flag   = fill_q;
    assign wrong_cnt   = wrong_q;
    assign won         = (state_q == S_FIN);
`ifdef SUDOKU_LOCKOUT_EN
    assign lost        = (state_q == S_LOST);
`else
    assign lost        = 1'b0;
`endif

endmodule
